// File: rtl/sgd_sched.sv
// sgd_sched: loads serial training rows into memory, then schedules SGD datapath runs per row and epoch.
// Optional feature macro SGD_SCHED_LR_DECAY_EN: DP_LR = learn_rate + EPOCH_CNT[7:3], saturating at 15.
`default_nettype none

module sgd_sched #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               S,
  input  logic                               S_VALID,
  input  logic [3:0]                         feat,
  input  logic [7:0]                         epoch,
  input  logic [3:0]                         learn_rate,
  input  logic [ADDR_WIDTH-1:0]              data_points,
  output logic                               MEM_WE,
  output logic [ADDR_WIDTH-1:0]              MEM_ADDR,
  output logic [LENGTH*(MAX_FEATURES+1)-1:0] MEM_WDATA,
  output logic                               DP_START,
  output logic [ADDR_WIDTH-1:0]              DP_ADDR,
  output logic [3:0]                         DP_LR,
  input  logic                               DP_DONE,
  output logic [7:0]                         EPOCH_CNT,
  output logic                               BUSY,
  output logic                               SGD_DONE
);

  localparam int ROW_W = LENGTH * (MAX_FEATURES + 1);
  localparam int BIT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(LENGTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    rst_meta_q, rst_sync_q;
  logic [LENGTH-1:0]       sh_q, sh_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [3:0]              widx_q, widx_d;
  logic [ADDR_WIDTH-1:0]   row_q, row_d;
  logic [7:0]              epcnt_q, epcnt_d;
  logic [3:0]              feat_q, feat_d;
  logic [7:0]              epoch_q, epoch_d;
  logic [3:0]              lr_q, lr_d;
  logic [ADDR_WIDTH-1:0]   dp_q, dp_d;
  logic [ROW_W-1:0]        rowbuf_q, rowbuf_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic                    last_q, last_d;
  logic                    w_shift;
  logic [LENGTH-1:0]       w_word;

  // Release is pushed through two flops so the first active edge trails RST rising.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign w_word = {S, sh_q[LENGTH-1:1]};

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    widx_d   = widx_q;
    row_d    = row_q;
    epcnt_d  = epcnt_q;
    feat_d   = feat_q;
    epoch_d  = epoch_q;
    lr_d     = lr_q;
    dp_d     = dp_q;
    rowbuf_d = rowbuf_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    last_d   = last_q;
    w_shift  = 1'b0;

    case (state_q)
      IDLE: begin
        if (S_VALID) begin
          feat_d  = feat;
          epoch_d = epoch;
          lr_d    = learn_rate;
          dp_d    = data_points;
          widx_d  = feat;
          w_shift = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (last_q) begin
          state_d = (epoch_q == 8'd0) ? DONE : ISSUE;
        end else if (S_VALID) begin
          w_shift = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (DP_DONE) begin
          state_d = ISSUE;
          if (row_q == dp_q) begin
            row_d   = '0;
            epcnt_d = epcnt_q + 8'd1;
            if (epcnt_q == epoch_q - 8'd1) state_d = DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Word k of a row lands in slot k; words arrive highest index first.
    if (w_shift) begin
      sh_d  = w_word;
      bit_d = bit_q + 1'b1;
      if (bit_q == LAST_BIT) begin
        bit_d = '0;
        for (int j = 0; j <= MAX_FEATURES; j++) begin
          if (widx_q == 4'(j)) rowbuf_d[LENGTH*j +: LENGTH] = w_word;
        end
        if (widx_q == 4'd0) begin
          we_d    = 1'b1;
          waddr_d = row_q;
          widx_d  = feat_q;
          if (row_q == dp_q) begin
            row_d  = '0;
            last_d = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          widx_d = widx_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      bit_q    <= '0;
      widx_q   <= '0;
      row_q    <= '0;
      epcnt_q  <= '0;
      feat_q   <= '0;
      epoch_q  <= '0;
      lr_q     <= '0;
      dp_q     <= '0;
      rowbuf_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      widx_q   <= widx_d;
      row_q    <= row_d;
      epcnt_q  <= epcnt_d;
      feat_q   <= feat_d;
      epoch_q  <= epoch_d;
      lr_q     <= lr_d;
      dp_q     <= dp_d;
      rowbuf_q <= rowbuf_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      last_q   <= last_d;
    end
  end

  assign MEM_WE    = we_q;
  assign MEM_ADDR  = waddr_q;
  assign MEM_WDATA = rowbuf_q;
  assign DP_START  = (state_q == ISSUE);
  assign DP_ADDR   = row_q;
  assign EPOCH_CNT = epcnt_q;
  assign BUSY      = (state_q == LOAD) || (state_q == ISSUE) || (state_q == WAIT);
  assign SGD_DONE  = (state_q == DONE);

`ifdef SGD_SCHED_LR_DECAY_EN
  logic [5:0] w_lr_sum;
  assign w_lr_sum = {2'b00, lr_q} + {1'b0, epcnt_q[7:3]};
  assign DP_LR    = (|w_lr_sum[5:4]) ? 4'hF : w_lr_sum[3:0];
`else
  assign DP_LR = lr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sgd_sched.sv
// tb_sgd_sched: directed scoreboard bench for sgd_sched (row writes and DP_START stream checked by a monitor).
`default_nettype none

module tb_sgd_sched;
  localparam int AW = 12;
  localparam int MF = 15;
  localparam int L  = 16;
  localparam int RW = L * (MF + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          S = 1'b0, S_VALID = 1'b0, DP_DONE = 1'b0;
  logic [3:0]    feat = '0, learn_rate = '0;
  logic [7:0]    epoch = '0;
  logic [AW-1:0] data_points = '0;
  logic          MEM_WE, DP_START, BUSY, SGD_DONE;
  logic [AW-1:0] MEM_ADDR, DP_ADDR;
  logic [RW-1:0] MEM_WDATA;
  logic [3:0]    DP_LR;
  logic [7:0]    EPOCH_CNT;

  sgd_sched #(.ADDR_WIDTH(AW), .MAX_FEATURES(MF), .LENGTH(L)) dut (
    .CLK(CLK), .RST(RST), .S(S), .S_VALID(S_VALID), .feat(feat), .epoch(epoch),
    .learn_rate(learn_rate), .data_points(data_points), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .DP_START(DP_START), .DP_ADDR(DP_ADDR), .DP_LR(DP_LR),
    .DP_DONE(DP_DONE), .EPOCH_CNT(EPOCH_CNT), .BUSY(BUSY), .SGD_DONE(SGD_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [AW-1:0] addr; logic [RW-1:0] data; } wr_t;
  typedef struct packed { logic [AW-1:0] addr; logic [3:0] lr; logic [7:0] ep; } dp_t;

  wr_t wr_q[$];
  dp_t dp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, last_start = -100;
  bit  resp_en = 1'b0, early = 1'b0, scramble = 1'b0;
  int  resp_delay = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_outs"}, 64'({MEM_WE, MEM_ADDR, DP_START, DP_ADDR, DP_LR, EPOCH_CNT, BUSY, SGD_DONE}), 64'd0);
    chk({nm, "_wdata"}, 64'(MEM_WDATA == '0), 64'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [15:0] word_of(input int seed, input int r, input int k);
    if (seed == 0) return (k == 1) ? 16'hBEEF : 16'h1234;
    return 16'((r * 40503 + k * 1021 + seed * 7919) ^ 32'h0000A5C3);
  endfunction

  function automatic logic [3:0] exp_lr(input logic [3:0] lr, input int ep);
    int s;
`ifdef SGD_SCHED_LR_DECAY_EN
    s = int'(lr) + ep / 8;
`else
    s = int'(lr) + 0 * ep;
`endif
    return (s > 15) ? 4'hF : 4'(s);
  endfunction

  task automatic send_word(input logic [15:0] w, input bit gap);
    for (int b = 0; b < L; b++) begin
      if (gap && b == 7) begin
        S_VALID = 1'b0;
        repeat (3) begin
          S = 1'($urandom);
          @(negedge CLK);
        end
      end
      S = w[b];
      S_VALID = 1'b1;
      @(negedge CLK);
      if (scramble) begin
        feat = 4'($urandom); epoch = 8'($urandom);
        learn_rate = 4'($urandom); data_points = AW'($urandom);
        scramble = 1'b0;
      end
    end
  endtask

  // Queues expected writes and DP requests, then streams rows; returns at the negedge of the last MEM_WE.
  task automatic load(input logic [3:0] f, input int dpn, input logic [7:0] ep,
                      input logic [3:0] lr, input int seed, input bit gap);
    wr_t e;
    dp_t d;
    feat = f; data_points = AW'(dpn); epoch = ep; learn_rate = lr; scramble = 1'b1;
    for (int p = 0; p < int'(ep); p++) begin
      for (int r = 0; r <= dpn; r++) begin
        d.addr = AW'(r); d.lr = exp_lr(lr, p); d.ep = 8'(p);
        dp_q.push_back(d);
      end
    end
    for (int r = 0; r <= dpn; r++) begin
      e.addr = AW'(r);
      e.data = '0;
      for (int k = int'(f); k >= 0; k--) e.data[L*k +: L] = word_of(seed, r, k);
      wr_q.push_back(e);
      for (int k = int'(f); k >= 0; k--) send_word(word_of(seed, r, k), gap);
    end
    S_VALID = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, input logic [7:0] ep);
    int i = 0;
    while (SGD_DONE !== 1'b1 && i < budget) begin
      @(negedge CLK);
      i++;
    end
    chk({nm, "_done"}, 64'(SGD_DONE), 64'd1);
    tick(2);
    chk({nm, "_done_hold"}, 64'({SGD_DONE, BUSY}), 64'd2);
    chk({nm, "_epoch_cnt"}, 64'(EPOCH_CNT), 64'(ep));
    chk({nm, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    chk({nm, "_dp_left"}, 64'(dp_q.size()), 64'd0);
  endtask

  task automatic do_reset(input string nm);
    #2 RST = 1'b0;
    #1 chk_zero(nm);
    resp_en = 1'b0;
    tick(5);
    chk_zero({nm, "_held"});
    wr_q.delete();
    dp_q.delete();
    RST = 1'b1;
    tick(4);
    resp_en = 1'b1;
  endtask

  always @(negedge CLK) begin : mon
    wr_t ew;
    dp_t ed;
    cyc = cyc + 1;
    if (MEM_WE === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mem_we_unexpected: got write to %0d, expected none", MEM_ADDR);
      end else begin
        ew = wr_q.pop_front();
        chk("mem_addr", 64'(MEM_ADDR), 64'(ew.addr));
        checks++;
        if (MEM_WDATA !== ew.data) begin
          errors++;
          $display("FAIL mem_wdata row %0d: got %h expected %h", ew.addr, MEM_WDATA, ew.data);
        end
      end
    end
    if (DP_START === 1'b1) begin
      chk("dp_spacing", 64'(cyc - last_start >= 2), 64'd1);
      last_start = cyc;
      if (dp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dp_start_unexpected: got start addr %0d, expected none", DP_ADDR);
      end else begin
        ed = dp_q.pop_front();
        chk("dp_start", 64'({DP_ADDR, DP_LR, EPOCH_CNT}), 64'({ed.addr, ed.lr, ed.ep}));
      end
    end
  end

  always begin : resp
    @(negedge CLK);
    while (resp_en && DP_START === 1'b1) begin
      if (early) DP_DONE = 1'b1;
      @(negedge CLK);
      DP_DONE = 1'b0;
      repeat (resp_delay) @(negedge CLK);
      DP_DONE = 1'b1;
      @(negedge CLK);
      DP_DONE = 1'b0;
    end
  end

  initial begin
    #1 RST = 1'b0;
    tick(3);
    chk_zero("reset");
    RST = 1'b1;
    tick(4);
    resp_en = 1'b1;

    // Single row, two words: slot1=BEEF, slot0=1234.
    load(4'd1, 0, 8'd1, 4'd5, 0, 1'b0);
    wait_done("t1", 100, 8'd1);

    // Mid-word S_VALID gaps and DP_DONE raised during ISSUE.
    do_reset("r2");
    early = 1'b1; resp_delay = 0;
    load(4'd2, 2, 8'd3, 4'd3, 7, 1'b1);
    wait_done("t_gap", 500, 8'd3);
    early = 1'b0; resp_delay = 1;

    // Zero epochs: DONE one cycle after the last write, no DP_START.
    do_reset("r3");
    load(4'd0, 1, 8'd0, 4'd1, 3, 1'b0);
    chk("e0_last_we", 64'({MEM_WE, SGD_DONE}), 64'd2);
    tick(1);
    chk("e0_done_next", 64'({SGD_DONE, BUSY}), 64'd2);
    wait_done("t_e0", 10, 8'd0);

    // Reset in the middle of epoch 3, then a clean reload.
    do_reset("r4");
    load(4'd0, 1, 8'd6, 4'd4, 5, 1'b0);
    for (int i = 0; i < 400 && !(EPOCH_CNT == 8'd3 && DP_START === 1'b1); i++) @(negedge CLK);
    chk("ep3_reached", 64'({EPOCH_CNT, DP_START}), 64'({8'd3, 1'b1}));
    do_reset("mid_ep3");
    load(4'd1, 1, 8'd2, 4'd6, 9, 1'b0);
    wait_done("t_reload", 200, 8'd2);

    // Full-size run: 100 rows of 15 words, 25 epochs.
    do_reset("r5");
    load(4'd14, 99, 8'd25, 4'd2, 11, 1'b0);
    wait_done("t_big", 10000, 8'd25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/sgd_sched.md
SGD_SCHED -- requirements
Module: sgd_sched

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning the width of the data-point address and count.
REQ-002 SHALL have parameter MAX_FEATURES, default 15, meaning the maximum feature index held per row.
REQ-003 SHALL have parameter LENGTH, default 16, meaning bits per serial word.
REQ-004 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port S  input  1  serial data, LSB first.
REQ-007 SHALL have port S_VALID  input  1  qualifies S for one bit per cycle.
REQ-008 SHALL have port feat  input  4  highest feature index in use.
REQ-009 SHALL have port epoch  input  8  number of epochs.
REQ-010 SHALL have port learn_rate  input  4  learning-rate shift amount.
REQ-011 SHALL have port data_points  input  ADDR_WIDTH  last data-point index, so data_points+1 rows.
REQ-012 SHALL have port MEM_WE  output  1  row write strobe.
REQ-013 SHALL have port MEM_ADDR  output  ADDR_WIDTH  row write address.
REQ-014 SHALL have port MEM_WDATA  output  LENGTH*(MAX_FEATURES+1)  row data, word j in bits [LENGTH*j +: LENGTH].
REQ-015 SHALL have port DP_START  output  1  one-cycle request to the SGD datapath.
REQ-016 SHALL have port DP_ADDR  output  ADDR_WIDTH  row the datapath processes.
REQ-017 SHALL have port DP_LR  output  4  shift amount for the current epoch.
REQ-018 SHALL have port DP_DONE  input  1  datapath completion pulse.
REQ-019 SHALL have port EPOCH_CNT  output  8  current epoch index.
REQ-020 SHALL have port BUSY  output  1  high in LOAD, ISSUE and WAIT.
REQ-021 SHALL have port SGD_DONE  output  1  training complete.

Function
REQ-022 SHALL implement FSM states IDLE, LOAD, ISSUE, WAIT and DONE.
REQ-023 In IDLE, the first S_VALID=1 cycle SHALL latch feat, epoch, learn_rate and data_points, and that bit SHALL count as bit 0 of the first word; the block SHALL then enter LOAD.
REQ-024 Configuration inputs SHALL be ignored after they are latched, until reset.
REQ-025 In LOAD, each S_VALID=1 cycle SHALL shift one bit in, LSB first; cycles with S_VALID=0 SHALL hold all state.
REQ-026 Words of a row SHALL arrive in index order feat down to 0, and word k SHALL be placed in slot k.
REQ-027 Slots above feat SHALL be written as zero.
REQ-028 MEM_WE SHALL pulse for exactly one cycle, in the cycle after the last bit of word 0, with MEM_ADDR equal to the row index starting at 0.
REQ-029 After row data_points is written, the FSM SHALL go to ISSUE, and S_VALID SHALL be ignored from then on.
REQ-030 ISSUE SHALL assert DP_START for one cycle with DP_ADDR equal to the row and go to WAIT.
REQ-031 In WAIT, DP_DONE SHALL advance the row; DP_DONE outside WAIT SHALL be ignored.
REQ-032 Rows SHALL run 0..data_points; after the last row, EPOCH_CNT SHALL increment and the row SHALL wrap to 0.
REQ-033 When EPOCH_CNT reaches the latched epoch value, the FSM SHALL go to DONE; otherwise it SHALL return to ISSUE.
REQ-034 Minimum spacing between DP_START pulses SHALL be 2 cycles.
REQ-035 If the latched epoch value is 0, the FSM SHALL go from LOAD straight to DONE with no DP_START.
REQ-036 DONE SHALL hold SGD_DONE=1 and BUSY=0 until reset.
REQ-037 Counters SHALL not overflow: row is compared against data_points and EPOCH_CNT against epoch before incrementing.

Reset
REQ-038 RST=0 SHALL force state IDLE asynchronously, from any state and mid-word.
REQ-039 During RST=0, all outputs and counters SHALL be zero and the partial shift register SHALL be cleared.
REQ-040 Release SHALL be synchronised so the first active edge comes one full cycle after RST rises.

Configuration
REQ-041 With macro SGD_SCHED_LR_DECAY_EN defined, DP_LR SHALL equal the latched learn_rate plus EPOCH_CNT[7:3], saturating at 15.
REQ-042 Without SGD_SCHED_LR_DECAY_EN, DP_LR SHALL equal the latched learn_rate constantly.

Verification
REQ-043 feat=1, data_points=0, epoch=1: stream words 0xBEEF then 0x1234 -> one MEM_WE at addr 0, MEM_WDATA[31:0]=0xBEEF1234, upper bits 0; one DP_START at DP_ADDR 0; SGD_DONE=1 after DP_DONE.
REQ-044 feat=14, data_points=99, epoch=25: stream 100 rows -> 100 MEM_WE pulses at addresses 0..99, then 2500 DP_START pulses, EPOCH_CNT ending at 25.
REQ-045 epoch=0 -> no DP_START, and SGD_DONE rises in the cycle after the last MEM_WE.
REQ-046 S_VALID gaps of 3 cycles mid-word -> row data is identical to the gap-free stream; DP_DONE pulsed while in ISSUE -> ignored.
REQ-047 RST pulled low mid-epoch 3 -> all outputs 0 immediately; a fresh stream reloads and runs cleanly.
REQ-048 With SGD_SCHED_LR_DECAY_EN, learn_rate=2, epoch=25 -> DP_LR 2, 3, 4, 5 at epochs 0, 8, 16, 24.
